alu_share_arbiter: RTL and testbench

//   Shares one WIDTH-bit add/subtract unit between two requesters (port 0, port 1).

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets two requesters share one WIDTH-bit add/subtract unit. A request is
//   accepted with a valid/ready handshake and its operands are registered. The
//   shared unit is then driven for ALU_LAT cycles, and its result and overflow
//   flag are captured. The result goes back to the granted requester with a
//   valid/ready handshake. When both ports are valid in the same cycle, the
//   grant alternates between them (round robin).
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req_valid/ready_<n>     request handshake, port n = 0/1
//   req_a/b/op_<n>          operands and op (0 = A+B, 1 = A-B)
//   rsp_valid/ready_<n>     response handshake, port n = 0/1
//   rsp_d, rsp_ovf          captured result and overflow, shared by both ports
//   alu_a/b/op              operands driven to the shared unit
//   alu_d, alu_ovf          shared unit result and overflow
//   busy                    high while an operation is in flight or awaiting pickup
module alu_share_arbiter #(
    parameter int WIDTH   = 64,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic             req_op_0,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic             req_op_1,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_d,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rsp_d_q, rsp_d_d;
    logic               rsp_ovf_q, rsp_ovf_d;

    logic               pick;
    logic               accept;
    logic               rsp_ready_g;

    // Port chosen in IDLE: a lone valid port wins; on a tie the port that was
    // not served last wins. Meaningless when neither port is valid.
    assign pick   = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
    assign accept = (state_q == IDLE) && (req_valid_0 || req_valid_1);

    assign req_ready_0 = accept && !pick;
    assign req_ready_1 = accept &&  pick;

    // Only the granted port's rsp_ready matters; the other one is ignored.
    assign rsp_ready_g = grant_q ? rsp_ready_1 : rsp_ready_0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        rsp_d_d      = rsp_d_q;
        rsp_ovf_d    = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = pick;
                    a_d     = pick ? req_a_1  : req_a_0;
                    b_d     = pick ? req_b_1  : req_b_0;
                    op_d    = pick ? req_op_1 : req_op_0;
                    cnt_d   = CNT_W'(ALU_LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_d_d   = alu_d;
                    rsp_ovf_d = alu_ovf;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE (not straight to a new grant) keeps a
                // dead cycle between operations.
                if (rsp_ready_g) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_d_q      <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            rsp_d_q      <= rsp_d_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign rsp_d       = rsp_d_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_valid_0 = (state_q == RESP) && !grant_q;
    assign rsp_valid_1 = (state_q == RESP) &&  grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int W   = 64;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid_0, req_ready_0, req_op_0, rsp_valid_0, rsp_ready_0;
    logic [W-1:0] req_a_0, req_b_0;
    logic         req_valid_1, req_ready_1, req_op_1, rsp_valid_1, rsp_ready_1;
    logic [W-1:0] req_a_1, req_b_1;
    logic [W-1:0] rsp_d, alu_a, alu_b, alu_d;
    logic         rsp_ovf, alu_op, alu_ovf, busy;

    int   checks = 0;
    int   errors = 0;
    logic mdl_last;   // reference model: port served most recently

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0),
        .req_b_0(req_b_0), .req_op_0(req_op_0), .rsp_valid_0(rsp_valid_0),
        .rsp_ready_0(rsp_ready_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1),
        .req_b_1(req_b_1), .req_op_1(req_op_1), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_1(rsp_ready_1),
        .rsp_d(rsp_d), .rsp_ovf(rsp_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_d(alu_d), .alu_ovf(alu_ovf), .busy(busy)
    );

    // Shared add/sub unit: signed overflow from operand/result sign bits.
    assign alu_d   = alu_op ? alu_a - alu_b : alu_a + alu_b;
    assign alu_ovf = alu_op ? ((alu_a[W-1] ^ alu_b[W-1]) & (alu_d[W-1] ^ alu_a[W-1]))
                            : (~(alu_a[W-1] ^ alu_b[W-1]) & (alu_d[W-1] ^ alu_a[W-1]));

    // Reference result {ovf, d}: exact signed arithmetic one bit wider, overflow
    // when the wide result does not fit in W signed bits.
    function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic op);
        logic signed [W:0] sa, sb, r;
        sa = {a[W-1], a};
        sb = {b[W-1], b};
        r  = op ? sa - sb : sa + sb;
        return {r[W] != r[W-1], r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic op);
        if (p == 0) begin
            req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op;
        end else begin
            req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
        @(negedge clk);
        reset = 1'b0;
        mdl_last = 1'b1;
    endtask

    // Drives one transaction to completion with the valids already set up;
    // called at a falling edge and returns at a falling edge. Reports what it
    // saw; callers compare. flags: 1 no accept, 2 both ready, 4 no response,
    // 8 both rsp_valid, 16 bad signals while in flight, 32 unstable under backpressure.
    task automatic serve_one(input int bp, output int port, output logic [W-1:0] d,
                             output logic ovf, output int lat, output int flags);
        port = -1; lat = 0; flags = 0; d = '0; ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready_0 && req_ready_1) flags |= 2;
            if (req_ready_0) port = 0;
            else if (req_ready_1) port = 1;
            @(negedge clk);
            if (port >= 0) break;
        end
        if (port < 0) begin
            flags |= 1;
            return;
        end
        if (port == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
        lat = 1;
        while (lat < 20) begin
            #1;
            if (port == 0 ? rsp_valid_0 : rsp_valid_1) break;
            if (req_ready_0 || req_ready_1 || rsp_valid_0 || rsp_valid_1 || !busy) flags |= 16;
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            flags |= 4;
            return;
        end
        d = rsp_d; ovf = rsp_ovf;
        if (rsp_valid_0 && rsp_valid_1) flags |= 8;
        for (int i = 0; i < bp; i++) begin
            if (port == 0) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
            @(negedge clk);
            #1;
            if (!(port == 0 ? rsp_valid_0 : rsp_valid_1) || rsp_d !== d || rsp_ovf !== ovf
                || !busy || req_ready_0 || req_ready_1) flags |= 32;
        end
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        if (port == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
        @(negedge clk);
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
        req_a_0 = '0; req_b_0 = '0; req_op_0 = 0; req_a_1 = '0; req_b_1 = '0; req_op_1 = 0;
        mdl_last = 1'b1;
        #1;
        checks++;
        if ({busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_ovf, rsp_d} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got ovf=%b d=%h exp 0", rsp_ovf, rsp_d);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_alu got op=%b a=%h b=%h exp 0", alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b exp 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_single_p0();
        int p, lat, fl; logic [W-1:0] d; logic ovf;
        set_req(0, 64'd5, 64'd3, 1'b1);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (p !== 0 || d !== 64'd2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_p0 got port=%0d d=%h ovf=%b exp port=0 d=2 ovf=0", p, d, ovf);
        end
        checks++;
        if (lat !== LAT + 1 || fl !== 0) begin
            errors++;
            $display("FAIL single_p0_timing got lat=%0d flags=%0d exp lat=%0d flags=0", lat, fl, LAT + 1);
        end
        mdl_last = 1'b0;
    endtask

    task automatic test_round_robin();
        int p, lat, fl; logic [W-1:0] d; logic ovf;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 64'd10, 64'd4, 1'b1);
            set_req(1, 64'd7, 64'd8, 1'b0);
            serve_one(1, p, d, ovf, lat, fl);
            checks++;
            if (p !== 0 || d !== 64'd6 || ovf !== 1'b0 || fl !== 0) begin
                errors++;
                $display("FAIL rr_first round %0d got port=%0d d=%h flags=%0d exp port=0 d=6 flags=0", r, p, d, fl);
            end
            serve_one(0, p, d, ovf, lat, fl);
            checks++;
            if (p !== 1 || d !== 64'd15 || ovf !== 1'b0 || fl !== 0) begin
                errors++;
                $display("FAIL rr_second round %0d got port=%0d d=%h flags=%0d exp port=1 d=15 flags=0", r, p, d, fl);
            end
        end
        mdl_last = 1'b1;
    endtask

    task automatic test_overflow();
        int p, lat, fl; logic [W-1:0] d; logic ovf;
        set_req(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (d !== 64'h7FFF_FFFF_FFFF_FFFF || ovf !== 1'b1 || fl !== 0) begin
            errors++;
            $display("FAIL ovf_sub got d=%h ovf=%b flags=%0d exp d=7fffffffffffffff ovf=1", d, ovf, fl);
        end
        set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (p !== 1 || d !== 64'h8000_0000_0000_0000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add got port=%0d d=%h ovf=%b exp port=1 d=8000000000000000 ovf=1", p, d, ovf);
        end
        mdl_last = 1'b1;
    endtask

    task automatic test_wrap();
        int p, lat, fl; logic [W-1:0] d; logic ovf;
        set_req(0, 64'd0, 64'd1, 1'b1);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFF || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_sub got d=%h ovf=%b exp d=ffffffffffffffff ovf=0", d, ovf);
        end
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (d !== 64'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_add got d=%h ovf=%b exp d=0 ovf=0", d, ovf);
        end
        mdl_last = 1'b0;
    endtask

    task automatic test_backpressure();
        int p, lat, fl, bad; logic [W-1:0] d, d0; logic ovf, got; logic [W:0] exp;
        set_req(0, 64'd100, 64'd58, 1'b1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1; got = req_ready_0; @(negedge clk);
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got %b exp 1", got);
        end
        req_valid_0 = 1'b0;
        set_req(1, 64'd20, 64'd22, 1'b0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1; got = rsp_valid_0;
            if (!got) @(negedge clk);
        end
        d0 = rsp_d;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid_0 || rsp_valid_1 || rsp_d !== d0 || !busy || req_ready_0 || req_ready_1) bad++;
        end
        checks++;
        if (got !== 1'b1 || d0 !== 64'd42) begin
            errors++;
            $display("FAIL bp_result got valid=%b d=%h exp valid=1 d=2a", got, d0);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
        end
        rsp_ready_0 = 1'b1;
        @(negedge clk);
        rsp_ready_0 = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid_0, req_ready_1} !== 3'b001) begin
            errors++;
            $display("FAIL bp_release got busy/rsp_valid_0/req_ready_1=%b exp 001", {busy, rsp_valid_0, req_ready_1});
        end
        mdl_last = 1'b0;
        exp = ref_calc(64'd20, 64'd22, 1'b0);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (p !== 1 || {ovf, d} !== exp || fl !== 0) begin
            errors++;
            $display("FAIL bp_next got port=%0d d=%h flags=%0d exp port=1 d=%h", p, d, fl, exp[W-1:0]);
        end
        mdl_last = 1'b1;
    endtask

    task automatic test_reset_exec();
        int p, lat, fl, bad; logic [W-1:0] d; logic ovf, got;
        set_req(0, 64'd77, 64'd1, 1'b0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1; got = req_ready_0; @(negedge clk);
        end
        req_valid_0 = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (got !== 1'b1 || {busy, rsp_valid_0, rsp_valid_1} !== 3'b000) begin
            errors++;
            $display("FAIL rst_exec got accepted=%b busy/rsp_valid=%b exp 1/000", got, {busy, rsp_valid_0, rsp_valid_1});
        end
        @(negedge clk);
        reset = 1'b0;
        mdl_last = 1'b1;
        bad = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            #1;
            if (busy || rsp_valid_0 || rsp_valid_1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_exec_quiet got %0d active cycles exp 0", bad);
        end
        set_req(0, 64'd9, 64'd2, 1'b0);
        serve_one(0, p, d, ovf, lat, fl);
        checks++;
        if (p !== 0 || d !== 64'd11 || ovf !== 1'b0 || lat !== LAT + 1 || fl !== 0) begin
            errors++;
            $display("FAIL rst_exec_next got port=%0d d=%h lat=%0d flags=%0d exp port=0 d=b lat=%0d", p, d, lat, fl, LAT + 1);
        end
        mdl_last = 1'b0;
    endtask

    task automatic test_random();
        int p, lat, fl, mask, n, ep;
        logic [W-1:0] d, a0, b0, a1, b1;
        logic ovf, op0, op1;
        logic [W:0] exp;
        int order[2];
        for (int t = 0; t < 40; t++) begin
            mask = $urandom_range(1, 3);
            a0 = rnd_val(); b0 = rnd_val(); op0 = 1'($urandom_range(0, 1));
            a1 = rnd_val(); b1 = rnd_val(); op1 = 1'($urandom_range(0, 1));
            if (mask[0]) set_req(0, a0, b0, op0);
            if (mask[1]) set_req(1, a1, b1, op1);
            n = 0;
            if (mask == 3) begin
                order[0] = mdl_last ? 0 : 1;
                order[1] = mdl_last ? 1 : 0;
                n = 2;
            end else begin
                order[0] = (mask == 2) ? 1 : 0;
                n = 1;
            end
            for (int k = 0; k < n; k++) begin
                ep  = order[k];
                exp = (ep == 0) ? ref_calc(a0, b0, op0) : ref_calc(a1, b1, op1);
                serve_one($urandom_range(0, 3), p, d, ovf, lat, fl);
                $display("txn %0d.%0d port %0d d %h ovf %0b lat %0d", t, k, p, d, ovf, lat);
                checks++;
                if (p !== ep) begin
                    errors++;
                    $display("FAIL rnd_grant txn %0d got port=%0d exp %0d", t, p, ep);
                end
                checks++;
                if ({ovf, d} !== exp) begin
                    errors++;
                    $display("FAIL rnd_result txn %0d got ovf=%b d=%h exp ovf=%b d=%h", t, ovf, d, exp[W], exp[W-1:0]);
                end
                checks++;
                if (lat !== LAT + 1 || fl !== 0) begin
                    errors++;
                    $display("FAIL rnd_timing txn %0d got lat=%0d flags=%0d exp lat=%0d flags=0", t, lat, fl, LAT + 1);
                end
                mdl_last = (ep == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_p0();
        test_round_robin();
        test_overflow();
        test_wrap();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
